bnn_inference_controller: RTL

Top-level sequencer for one MNIST BNN inference. Accepts a pixel stream, writes it into the input buffer, then drives the shared 3-bit state bus through the load and three layer phases. It waits on each layer's done flag, captures the final-layer class index, and presents it on a valid/ready result port. It is the sole driver of the `state` bus consumed by every layer, including the flatten/final layer.

---
 rtl/bnn_inference_controller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bnn_inference_controller.sv
// bnn_inference_controller: sequences one BNN inference (pixel load, three layer phases,
// result handshake) and is the sole driver of the shared phase bus.
`timescale 1ns/1ps
`default_nettype none

module bnn_inference_controller #(
   parameter int NUM_PIXELS     = 784,
   parameter int PIX_PER_BEAT   = 8,
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int ADDR_W         = $clog2(NUM_PIXELS / PIX_PER_BEAT)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    pixel_valid,
   input  logic [PIX_PER_BEAT-1:0] pixel_data,
   output logic                    pixel_ready,
   output logic                    pixel_wr_en,
   output logic [ADDR_W-1:0]       pixel_wr_addr,
   output logic [PIX_PER_BEAT-1:0] pixel_wr_data,
   output logic [2:0]              state,
   input  logic                    layer_1_done,
   input  logic                    layer_2_done,
   input  logic                    layer_3_done,
   input  logic [3:0]              answer_in,
   output logic [3:0]              result,
   output logic                    result_valid,
   input  logic                    result_ready,
   output logic                    busy,
   output logic                    error
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_LOAD    = 3'b001,
      S_LAYER_1 = 3'b010,
      S_LAYER_2 = 3'b011,
      S_LAYER_3 = 3'b100,
      S_DONE    = 3'b101
   } state_t;

   localparam int                NUM_BEATS = NUM_PIXELS / PIX_PER_BEAT;
   localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NUM_BEATS - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t              cur_state;
   state_t              nxt_state;
   logic [ADDR_W-1:0]   beat_cnt;
   logic                dwell;
   logic [TMO_W-1:0]    tmo_cnt;
   logic                in_layer;
   logic                layer_done_sel;
   logic                done_ok;
   logic                timed_out;

   assign pixel_ready   = (cur_state == S_LOAD);
   assign pixel_wr_en   = pixel_valid && pixel_ready;
   assign pixel_wr_addr = beat_cnt;
   assign pixel_wr_data = pixel_data;
   assign state         = cur_state;

   // dwell is zero on the entry cycle, so a stale done left over from the previous image is masked
   always_comb begin
      layer_done_sel = 1'b0;
      in_layer       = 1'b0;
      case (cur_state)
         S_LAYER_1: begin layer_done_sel = layer_1_done; in_layer = 1'b1; end
         S_LAYER_2: begin layer_done_sel = layer_2_done; in_layer = 1'b1; end
         S_LAYER_3: begin layer_done_sel = layer_3_done; in_layer = 1'b1; end
         default:   ;
      endcase
      done_ok   = in_layer && dwell && layer_done_sel;
      timed_out = in_layer && (tmo_cnt == TMO_LAST);
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_IDLE:    if (start) nxt_state = S_LOAD;
         S_LOAD:    if (pixel_wr_en && beat_cnt == LAST_BEAT) nxt_state = S_LAYER_1;
         S_LAYER_1: if (done_ok) nxt_state = S_LAYER_2; else if (timed_out) nxt_state = S_IDLE;
         S_LAYER_2: if (done_ok) nxt_state = S_LAYER_3; else if (timed_out) nxt_state = S_IDLE;
         S_LAYER_3: if (done_ok) nxt_state = S_DONE;    else if (timed_out) nxt_state = S_IDLE;
         S_DONE:    if (result_valid && result_ready) nxt_state = S_IDLE;
         default:   nxt_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_state    <= S_IDLE;
         beat_cnt     <= '0;
         dwell        <= 1'b0;
         tmo_cnt      <= '0;
         result       <= 4'd0;
         result_valid <= 1'b0;
         error        <= 1'b0;
         busy         <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         busy      <= (nxt_state != S_IDLE);

         if (cur_state == S_IDLE && start) begin
            beat_cnt <= '0;
            error    <= 1'b0;
         end else if (pixel_wr_en) begin
            beat_cnt <= beat_cnt + ADDR_W'(1);
         end

         // both counters restart on every state change; the timeout counter saturates
         if (nxt_state != cur_state) begin
            dwell   <= 1'b0;
            tmo_cnt <= '0;
         end else begin
            dwell <= 1'b1;
            if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + TMO_W'(1);
         end

         if (cur_state == S_LAYER_3 && done_ok) begin
            result       <= answer_in;
            result_valid <= 1'b1;
         end else if (cur_state == S_DONE && result_ready) begin
            result_valid <= 1'b0;
         end

         if (timed_out && !done_ok) error <= 1'b1;
      end
   end

endmodule

`default_nettype wire
